// File: rtl/aes_round_ctrl_if.sv
// Signal bundle between the AES round sequencer and its environment:
// block input, key store, shared round datapath and ciphertext output.
interface aes_round_ctrl_if #(
    parameter int DATA_WIDTH  = 128,
    parameter int ROUND_WIDTH = 4
);
    // Block input handshake
    logic                   start_valid_in;
    logic                   start_ready_out;
    logic [DATA_WIDTH-1:0]  data_in;

    // Key store
    logic [ROUND_WIDTH-1:0] key_idx_out;
    logic [DATA_WIDTH-1:0]  round_key_in;

    // Round datapath request/response
    logic                   round_valid_out;
    logic [DATA_WIDTH-1:0]  round_data_out;
    logic [ROUND_WIDTH-1:0] round_num_out;
    logic                   round_last_out;
    logic                   round_valid_in;
    logic [DATA_WIDTH-1:0]  round_data_in;

    // Ciphertext output handshake and status
    logic                   cipher_valid_out;
    logic                   cipher_ready_in;
    logic [DATA_WIDTH-1:0]  cipher_data_out;
    logic                   busy_out;
    logic                   protocol_err_out;

    // Controller side
    modport master (
        input  start_valid_in, data_in, round_key_in, round_valid_in,
               round_data_in, cipher_ready_in,
        output start_ready_out, key_idx_out, round_valid_out, round_data_out,
               round_num_out, round_last_out, cipher_valid_out,
               cipher_data_out, busy_out, protocol_err_out
    );

    // Environment side (block source, key store, datapath, sink)
    modport slave (
        output start_valid_in, data_in, round_key_in, round_valid_in,
               round_data_in, cipher_ready_in,
        input  start_ready_out, key_idx_out, round_valid_out, round_data_out,
               round_num_out, round_last_out, cipher_valid_out,
               cipher_data_out, busy_out, protocol_err_out
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encrypt sequencer: owns the state register, does the
// key-0 whitening, then drives NUM_ROUNDS passes through an external round datapath.
module aes_round_ctrl #(
    parameter int DATA_WIDTH  = 128,
    parameter int NUM_ROUNDS  = 10,
    parameter int ROUND_WIDTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    aes_round_ctrl_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [ROUND_WIDTH-1:0] LAST_ROUND = ROUND_WIDTH'(NUM_ROUNDS);

    state_e                 st_q,   st_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic [ROUND_WIDTH-1:0] cnt_q,  cnt_d;
    logic                   err_q,  err_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st_q   <= ST_IDLE;
            data_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        st_d   = st_q;
        data_d = data_q;
        cnt_d  = cnt_q;
        err_d  = err_q;

        unique case (st_q)
            ST_IDLE: begin
                // A result arriving with no round outstanding is flagged and dropped.
                if (bus.round_valid_in) begin
                    err_d = 1'b1;
                end
                if (bus.start_valid_in) begin
                    data_d = bus.data_in ^ bus.round_key_in;
                    cnt_d  = ROUND_WIDTH'(1);
                    st_d   = ST_ISSUE;
                end
            end

            ST_ISSUE, ST_WAIT: begin
                // A zero-latency datapath answers during ISSUE itself.
                if (bus.round_valid_in) begin
                    data_d = bus.round_data_in;
                    if (cnt_q == LAST_ROUND) begin
                        st_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + ROUND_WIDTH'(1);
                        st_d  = ST_ISSUE;
                    end
                end else begin
                    st_d = ST_WAIT;
                end
            end

            ST_DONE: begin
                if (bus.round_valid_in) begin
                    err_d = 1'b1;
                end
                if (bus.cipher_ready_in) begin
                    st_d = ST_IDLE;
                end
            end

            default: st_d = ST_IDLE;
        endcase
    end

    logic round_active;
    assign round_active = (st_q == ST_ISSUE) || (st_q == ST_WAIT);

    assign bus.start_ready_out  = (st_q == ST_IDLE);
    assign bus.busy_out         = (st_q != ST_IDLE);
    assign bus.round_valid_out  = (st_q == ST_ISSUE);
    assign bus.round_data_out   = round_active ? data_q : '0;
    assign bus.round_num_out    = round_active ? cnt_q  : '0;
    assign bus.key_idx_out      = round_active ? cnt_q  : '0;
    assign bus.round_last_out   = round_active && (cnt_q == LAST_ROUND);
    assign bus.cipher_valid_out = (st_q == ST_DONE);
    assign bus.cipher_data_out  = (st_q == ST_DONE) ? data_q : '0;
    assign bus.protocol_err_out = err_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: reference AES key store and round datapath with
// selectable latency, scoreboard of expected ciphertexts, directed test sequence.
module tb_aes_round_ctrl;

    localparam int DW = 128;
    localparam int RW = 4;
    localparam int NR = 10;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    aes_round_ctrl_if #(.DATA_WIDTH(DW), .ROUND_WIDTH(RW)) bus ();

    aes_round_ctrl #(.DATA_WIDTH(DW), .NUM_ROUNDS(NR), .ROUND_WIDTH(RW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_txn    = 0;

    logic [127:0] key      = FIPS_KEY;
    int           lat_mode = 0;
    bit           lat_rand = 1'b0;
    bit           spur     = 1'b0;
    int           gen      = 0;
    logic         dp_valid = 1'b0;
    logic [127:0] dp_data  = '0;
    int           lat_exp  = 0;

    logic [127:0] sb [$];

    int           t_start   = 0;
    int           t_hs      = 0;
    int           pulses    = 0;
    int           exp_round = 1;
    logic [127:0] iss_data  = '0;
    logic [3:0]   iss_idx   = '0;
    logic         prev_cv   = 1'b0;
    logic [127:0] held_c    = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- AES reference arithmetic ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // Inverse as x^254, then the FIPS-197 affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] sq;
        inv = 8'h01;
        sq  = x;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) inv = gmul(inv, sq);
            sq = gmul(sq, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] round_key(input logic [127:0] k, input logic [3:0] idx);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        int          ii;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        ii = int'(idx);
        if (ii > 10) return '0;
        return {w[4*ii], w[4*ii+1], w[4*ii+2], w[4*ii+3]};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[4*c+r] = b[4*((c+r)%4)+r];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o ^ k;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] k);
        logic [127:0] s;
        s = pt ^ round_key(k, 4'd0);
        for (int r = 1; r <= NR; r++) s = aes_round(s, round_key(k, 4'(r)), r == NR);
        return s;
    endfunction

    // ---------------- environment: key store and round datapath ----------------
    assign bus.round_key_in   = round_key(key, bus.key_idx_out);
    assign bus.round_valid_in = spur | ((lat_mode == 0) ? bus.round_valid_out : dp_valid);
    assign bus.round_data_in  = spur ? '1 :
                                (lat_mode == 0) ? aes_round(bus.round_data_out, bus.round_key_in,
                                                            bus.round_last_out)
                                                : dp_data;

    // Delayed datapath: answers L cycles after the issue cycle; a reset in between cancels it.
    initial begin
        forever begin
            @(negedge clk);
            dp_valid = 1'b0;
            if (lat_mode != 0 && reset_n && bus.round_valid_out === 1'b1) begin
                automatic int           l = lat_rand ? int'($urandom_range(1, 5)) : lat_mode;
                automatic int           g = gen;
                automatic logic [127:0] r = aes_round(bus.round_data_out, bus.round_key_in,
                                                      bus.round_last_out);
                repeat (l) @(negedge clk);
                if (g == gen) begin
                    dp_valid = 1'b1;
                    dp_data  = r;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        n_checks++;
        n_fail++;
        $error("FAIL %s timeout observed=expired expected=event", tag);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_cv = 1'b0;
                continue;
            end
            if (bus.start_valid_in && bus.start_ready_out) begin
                t_start   = cyc;
                pulses    = 0;
                exp_round = 1;
            end
            if (bus.round_valid_out) begin
                pulses++;
                chk("round_num",  128'(bus.round_num_out),  128'(exp_round));
                chk("key_idx",    128'(bus.key_idx_out),    128'(exp_round));
                chk("round_last", 128'(bus.round_last_out), 128'(exp_round == NR));
                iss_data = bus.round_data_out;
                iss_idx  = bus.key_idx_out;
                exp_round++;
            end else if (bus.busy_out && !bus.cipher_valid_out) begin
                chk("wait_data", bus.round_data_out,     iss_data);
                chk("wait_idx",  128'(bus.key_idx_out),  128'(iss_idx));
            end
            if (bus.cipher_valid_out && !prev_cv) begin
                chk("pulses", 128'(pulses), 128'(NR));
                if (lat_exp != 0) chk("latency", 128'(cyc - t_start), 128'(lat_exp));
                held_c = bus.cipher_data_out;
            end else if (bus.cipher_valid_out) begin
                chk("cipher_hold", bus.cipher_data_out, held_c);
            end
            if (bus.cipher_valid_out) chk("start_ready_done", 128'(bus.start_ready_out), 128'(0));
            if (bus.cipher_valid_out && bus.cipher_ready_in) begin
                t_hs = cyc;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $error("FAIL cipher_unexpected observed=%h expected=none", bus.cipher_data_out);
                end else begin
                    automatic logic [127:0] e = sb.pop_front();
                    n_txn++;
                    $display("txn %0d cycle %0d cipher=%h expected=%h", n_txn, cyc,
                             bus.cipher_data_out, e);
                    chk("cipher", bus.cipher_data_out, e);
                end
            end
            prev_cv = bus.cipher_valid_out;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic send(input logic [127:0] pt, input logic [127:0] expct);
        bit ok;
        ok = 1'b0;
        sb.push_back(expct);
        bus.data_in        = pt;
        bus.start_valid_in = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (bus.start_ready_out) ok = 1'b1;
        end
        if (!ok) timeout_fail("start_accept");
        @(posedge clk); #1;
        bus.start_valid_in = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        int i;
        i = 0;
        while (sb.size() != 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (sb.size() != 0) begin
            timeout_fail(tag);
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic check_idle(input string tag, input logic err);
        chk({tag, "_start_ready"}, 128'(bus.start_ready_out),  128'(1));
        chk({tag, "_busy"},        128'(bus.busy_out),         128'(0));
        chk({tag, "_round_valid"}, 128'(bus.round_valid_out),  128'(0));
        chk({tag, "_round_data"},  bus.round_data_out,         128'(0));
        chk({tag, "_round_num"},   128'(bus.round_num_out),    128'(0));
        chk({tag, "_round_last"},  128'(bus.round_last_out),   128'(0));
        chk({tag, "_key_idx"},     128'(bus.key_idx_out),      128'(0));
        chk({tag, "_cipher_valid"},128'(bus.cipher_valid_out), 128'(0));
        chk({tag, "_cipher_data"}, bus.cipher_data_out,        128'(0));
        chk({tag, "_perr"},        128'(bus.protocol_err_out), 128'(err));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [127:0] pt_r;
        bit           ok;

        bus.start_valid_in  = 1'b0;
        bus.data_in         = '0;
        bus.cipher_ready_in = 1'b1;
        reset_n             = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check_idle("reset", 1'b0);
        @(posedge clk); #1;

        // 1: FIPS-197 C.1, zero-latency datapath
        lat_mode = 0; lat_exp = 11;
        send(FIPS_PT, FIPS_CT);
        drain("t1_done", 100);

        // 2: one-cycle datapath, then random 1..5 cycle latency
        lat_mode = 1; lat_exp = 21;
        send(FIPS_PT, FIPS_CT);
        drain("t2a_done", 200);
        lat_rand = 1'b1; lat_exp = 0;
        send(FIPS_PT, FIPS_CT);
        drain("t2b_done", 300);
        pt_r = {$urandom, $urandom, $urandom, $urandom};
        send(pt_r, aes_enc(pt_r, key));
        drain("t2c_done", 300);
        lat_rand = 1'b0;

        // 3: backpressure for 7 cycles with start_valid_in asserted meanwhile
        lat_mode = 0; lat_exp = 11;
        bus.cipher_ready_in = 1'b0;
        send(FIPS_PT, FIPS_CT);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (bus.cipher_valid_out) ok = 1'b1;
        end
        if (!ok) timeout_fail("t3_valid");
        @(posedge clk); #1;
        bus.start_valid_in = 1'b1;
        bus.data_in        = '1;
        repeat (6) begin @(posedge clk); #1; end
        bus.cipher_ready_in = 1'b1;
        bus.start_valid_in  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_idle("t3_idle", 1'b0);
        drain("t3_done", 10);

        // 4: reset during the round-5 WAIT, then a clean FIPS block
        lat_mode = 5; lat_exp = 0;
        send(FIPS_PT, FIPS_CT);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (bus.round_valid_out && bus.round_num_out == 4'd5) ok = 1'b1;
        end
        if (!ok) timeout_fail("t4_round5");
        @(posedge clk); #1;
        reset_n = 1'b0;
        gen++;
        @(posedge clk); #1;
        reset_n = 1'b1;
        sb.delete();
        lat_mode = 0;
        @(negedge clk);
        check_idle("t4_rst", 1'b0);
        @(posedge clk); #1;
        lat_exp = 11;
        send(FIPS_PT, FIPS_CT);
        drain("t4_done", 100);

        // 5: spurious datapath result while idle
        spur = 1'b1;
        @(posedge clk); #1;
        spur = 1'b0;
        @(negedge clk);
        chk("t5_perr_set", 128'(bus.protocol_err_out), 128'(1));
        chk("t5_busy",     128'(bus.busy_out),         128'(0));
        @(posedge clk); #1;
        pt_r = {$urandom, $urandom, $urandom, $urandom};
        send(pt_r, aes_enc(pt_r, key));
        drain("t5_done", 100);
        chk("t5_perr_sticky", 128'(bus.protocol_err_out), 128'(1));

        // 6: back-to-back blocks with start_valid_in held high
        pt_r = {$urandom, $urandom, $urandom, $urandom};
        sb.push_back(FIPS_CT);
        sb.push_back(aes_enc(pt_r, key));
        bus.data_in        = FIPS_PT;
        bus.start_valid_in = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.start_ready_out) ok = 1'b1;
        end
        if (!ok) timeout_fail("t6_accept1");
        @(posedge clk); #1;
        bus.data_in = pt_r;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (bus.start_ready_out) ok = 1'b1;
        end
        if (!ok) timeout_fail("t6_accept2");
        chk("t6_b2b_gap", 128'(cyc), 128'(t_hs + 1));
        @(posedge clk); #1;
        bus.start_valid_in = 1'b0;
        drain("t6_done", 100);

        chk("final_perr", 128'(bus.protocol_err_out), 128'(1));
        chk("final_sb_empty", 128'(sb.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
Iterative AES-128 encrypt sequencer. It owns the 128-bit state register and performs the initial AddRoundKey whitening itself. It then issues NUM_ROUNDS passes through the external round datapath (subBytes -> shiftRow -> mixColumns -> addRoundKey) and selects the round-key index for the key store. It presents the ciphertext with a valid/ready handshake and sits between the block input interface and the shared round datapath.

Parameters:
DATA_WIDTH, 128, state/key width in bits; fixed at 128.
NUM_ROUNDS, 10, number of datapath rounds; the last round skips mixColumns.
ROUND_WIDTH, 4, width of the round counter and key index.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset_n  input  1  synchronous, active-low reset.
start_valid_in  input  1  plaintext on data_in is valid.
start_ready_out  output  1  controller can accept a new block.
data_in  input  DATA_WIDTH  plaintext block.
key_idx_out  output  ROUND_WIDTH  round-key index driven to the key store.
round_key_in  input  DATA_WIDTH  round key for key_idx_out; combinational, same cycle.
round_valid_out  output  1  one-cycle pulse issuing a round.
round_data_out  output  DATA_WIDTH  state sent to the round datapath.
round_num_out  output  ROUND_WIDTH  current round, 1..NUM_ROUNDS.
round_last_out  output  1  high when round_num_out==NUM_ROUNDS (datapath bypasses mixColumns).
round_valid_in  input  1  round datapath result valid.
round_data_in  input  DATA_WIDTH  round datapath result.
cipher_valid_out  output  1  ciphertext valid.
cipher_ready_in  input  1  downstream accepts the ciphertext.
cipher_data_out  output  DATA_WIDTH  ciphertext.
busy_out  output  1  high in any state other than IDLE.
protocol_err_out  output  1  sticky flag: round_valid_in was seen while no round was outstanding.

Behaviour:
- Reset (reset_n low at a rising edge; valid from any state, including mid-encryption):
  - state to IDLE; state_reg and round_cnt to 0.
  - All outputs 0 except start_ready_out=1.
  - protocol_err_out cleared; the in-flight block is discarded.
- IDLE:
  - start_ready_out=1, key_idx_out=0.
  - On start_valid_in: state_reg <= data_in ^ round_key_in (key 0), round_cnt <= 1, go to ISSUE.
- ISSUE:
  - round_valid_out=1 for this cycle only.
  - round_data_out=state_reg, round_num_out=round_cnt, key_idx_out=round_cnt, round_last_out=(round_cnt==NUM_ROUNDS).
  - If round_valid_in is high in this cycle, accept the result as in WAIT. Otherwise go to WAIT.
- WAIT:
  - round_data_out, round_num_out, key_idx_out and round_last_out held stable; round_valid_out=0.
  - On round_valid_in: state_reg <= round_data_in.
  - Then, if round_cnt==NUM_ROUNDS go to DONE; else round_cnt <= round_cnt+1 and go to ISSUE.
  - Wait time is unbounded; there is no timeout.
- DONE:
  - cipher_valid_out=1 and cipher_data_out=state_reg, both held stable until cipher_ready_in.
  - On cipher_ready_in go to IDLE. No new start is accepted in the same cycle (start_ready_out=0 in DONE).
- protocol_err_out:
  - Set when round_valid_in=1 in IDLE or DONE; such a pulse never modifies state_reg.
  - Stays set until reset.
- Outputs when idle: cipher_data_out=0 when cipher_valid_out=0; round_data_out=0 outside ISSUE/WAIT.
- Latency with a zero-latency datapath (round_valid_in tied to round_valid_out):
  - start accepted in cycle T.
  - ISSUE for rounds 1..10 in cycles T+1..T+10.
  - cipher_valid_out first high in cycle T+11.
- Latency with a datapath returning one cycle after issue: 2 cycles per round, so cipher_valid_out first high in T+21.
- busy_out = (state != IDLE).
- round_cnt never exceeds NUM_ROUNDS and does not wrap.

Test Plan:
1. FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff, with a reference round datapath and key store at zero latency -> cipher_data_out=69c4e0d86a7b0430d8cdb78070b4c55a at T+11; round_last_out high only in the round-10 issue cycle.
2. Same vector with datapath latency 1 cycle, then randomized 1..5 cycles -> identical ciphertext; round_valid_out pulses exactly 10 times; round_data_out and key_idx_out are stable across every WAIT cycle.
3. Backpressure: cipher_ready_in held low 7 cycles after cipher_valid_out rises -> output held constant; start_ready_out=0 and start_valid_in ignored throughout; IDLE entered on the cycle after ready goes high.
4. Reset mid-operation: reset_n low for 1 cycle during the round-5 WAIT -> next cycle in IDLE, all outputs 0, start_ready_out=1; a following FIPS vector still produces the correct ciphertext.
5. Spurious round_valid_in in IDLE with round_data_in=all-ones -> protocol_err_out=1 and stays set; the next encryption result is unaffected.
6. Back-to-back blocks, with start_valid_in held high and cipher_ready_in=1 -> the second block is accepted the cycle after the first DONE handshake; both ciphertexts match the reference model.
